// File: rtl/dcsk_pkg.sv
// ---------------------------------------------------------------------------
// dcsk_pkg
// Shared definitions for the DCSK transmit path: frame-generator state
// encoding, chip polarity constants and the default half-symbol length that
// both the chip delay line (DELAY) and the frame generator (BETA) use.
// ---------------------------------------------------------------------------
package dcsk_pkg;

   // Default chips per half-symbol; the delay line must be built with the
   // same value so information chips line up with their reference chips.
   localparam int DCSK_BETA = 8;

   // Chip encoding on the serial stream: 1 = +1, 0 = -1.
   localparam logic CHIP_POS = 1'b1;
   localparam logic CHIP_NEG = 1'b0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REF  = 2'd1,
      INFO = 2'd2
   } dcsk_frame_state_t;

endpackage

// File: rtl/dcsk_frame_gen_if.sv
// ---------------------------------------------------------------------------
// dcsk_frame_gen_if
// Data input handshake and serial chip output of the DCSK frame generator.
//
// Handshake: a data bit transfers on every cycle where data_valid and
// data_ready are both 1; data_ready never depends on data_valid. The chip
// output has no backpressure: the consumer takes one chip per cycle
// whenever tx_valid is 1.
//
//   data_bit    master -> slave  bit to modulate
//   data_valid  master -> slave  data_bit is valid
//   data_ready  slave -> master  generator accepts data_bit this cycle
//   tx_chip     slave -> master  modulated chip (registered)
//   tx_valid    slave -> master  tx_chip is a live frame chip
//   tx_ref      slave -> master  1 on reference chips, 0 on information chips
//   sym_start   slave -> master  pulse with first reference chip of a symbol
//   sym_done    slave -> master  pulse with last information chip of a symbol
// ---------------------------------------------------------------------------
interface dcsk_frame_gen_if;

   logic data_bit;
   logic data_valid;
   logic data_ready;
   logic tx_chip;
   logic tx_valid;
   logic tx_ref;
   logic sym_start;
   logic sym_done;

   modport master (
      output data_bit, data_valid,
      input  data_ready, tx_chip, tx_valid, tx_ref, sym_start, sym_done
   );

   modport slave (
      input  data_bit, data_valid,
      output data_ready, tx_chip, tx_valid, tx_ref, sym_start, sym_done
   );

endinterface

// File: rtl/dcsk_frame_gen.sv
// ---------------------------------------------------------------------------
// dcsk_frame_gen
// Transmit-side DCSK frame generator. For each accepted data bit it emits
// BETA reference chips copied from the chaos source, followed by BETA
// information chips formed as delayed_chip XNOR data bit. Sits beside a
// free-running chip delay line with DELAY = BETA.
//
// Ports:
//   clk           system clock
//   rst_n         synchronous active-low reset
//   chaos_chip    current chaos chip (also feeds the delay line)
//   delayed_chip  delay line output: chaos_chip from BETA cycles earlier
//   dif           data handshake + chip output (slave side)
//   state_o       current FSM state, for debug/observation
// ---------------------------------------------------------------------------
module dcsk_frame_gen
   import dcsk_pkg::*;
#(
   parameter int BETA = DCSK_BETA
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              chaos_chip,
   input  logic              delayed_chip,
   dcsk_frame_gen_if.slave   dif,
   output dcsk_frame_state_t state_o
);

   localparam int CNT_W = $clog2(BETA);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BETA - 1);

   dcsk_frame_state_t state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              sym_bit_q, sym_bit_d;
   logic              last_chip;
   logic              accept;

   logic tx_chip_q, tx_chip_d;
   logic tx_valid_q, tx_valid_d;
   logic tx_ref_q, tx_ref_d;
   logic sym_start_q, sym_start_d;
   logic sym_done_q, sym_done_d;

   assign last_chip = (cnt_q == CNT_LAST);

   // Ready in IDLE, or on the final information chip so the next symbol can
   // follow with no gap. Forced low while reset is asserted.
   assign dif.data_ready = rst_n &&
                           ((state_q == IDLE) || ((state_q == INFO) && last_chip));
   assign accept         = dif.data_valid && dif.data_ready;

   // Next state, chip counter and latched symbol bit
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sym_bit_d = accept ? dif.data_bit : sym_bit_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = REF;
               cnt_d   = '0;
            end
         end
         REF: begin
            if (last_chip) begin
               state_d = INFO;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         INFO: begin
            if (last_chip) begin
               state_d = accept ? REF : IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output registers are loaded from the chip of the state being entered,
   // so tx_chip trails its source chip by exactly one cycle. Because the
   // delay line is BETA deep, information chip k sees the same chaos sample
   // that produced reference chip k.
   always_comb begin
      tx_chip_d   = CHIP_NEG;
      tx_valid_d  = 1'b0;
      tx_ref_d    = 1'b0;
      sym_start_d = 1'b0;
      sym_done_d  = 1'b0;
      case (state_d)
         REF: begin
            tx_chip_d   = chaos_chip;
            tx_valid_d  = 1'b1;
            tx_ref_d    = 1'b1;
            sym_start_d = (cnt_d == '0);
         end
         INFO: begin
            tx_chip_d  = delayed_chip ~^ sym_bit_d;
            tx_valid_d = 1'b1;
            sym_done_d = (cnt_d == CNT_LAST);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sym_bit_q   <= 1'b0;
         tx_chip_q   <= CHIP_NEG;
         tx_valid_q  <= 1'b0;
         tx_ref_q    <= 1'b0;
         sym_start_q <= 1'b0;
         sym_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sym_bit_q   <= sym_bit_d;
         tx_chip_q   <= tx_chip_d;
         tx_valid_q  <= tx_valid_d;
         tx_ref_q    <= tx_ref_d;
         sym_start_q <= sym_start_d;
         sym_done_q  <= sym_done_d;
      end
   end

   assign dif.tx_chip   = tx_chip_q;
   assign dif.tx_valid  = tx_valid_q;
   assign dif.tx_ref    = tx_ref_q;
   assign dif.sym_start = sym_start_q;
   assign dif.sym_done  = sym_done_q;
   assign state_o       = state_q;

endmodule
